// File: rtl/output_dac_mch.sv
// Multi-channel serial DAC driver: clamps/offsets signed samples to DAC codes and shifts
// one framed word per channel, MSB first. Define OUTPUT_DAC_MCH_SKID_EN to add a pending-sample buffer.
module output_dac_mch #(
  parameter int CHANNELS  = 2,
  parameter int IN_BITS   = 32,
  parameter int SHIFT     = 8,
  parameter int DAC_BITS  = 12,
  parameter int CTRL_BITS = 4,
  parameter int DIV_BITS  = 4,
  parameter int GAP_BITS  = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         cke,
  input  logic [CHANNELS*IN_BITS-1:0]  s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic                         dac_sclk,
  output logic                         dac_sync_n,
  output logic [CHANNELS-1:0]          dac_din,
  output logic [15:0]                  ovr_count
);

  localparam int WORD_BITS = CTRL_BITS + DAC_BITS;
  localparam int BIT_W     = $clog2(WORD_BITS);
  localparam int GAP_W     = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic signed [IN_BITS-1:0] CLAMP_MAX = IN_BITS'((1 << (DAC_BITS-1)) - 1);
  localparam logic signed [IN_BITS-1:0] CLAMP_MIN = -CLAMP_MAX;
  localparam logic [DAC_BITS-1:0]       DAC_OFFSET = DAC_BITS'(1 << (DAC_BITS-1));

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_SHIFT, ST_GAP} state_e;

  state_e                            state_q, state_d;
  logic [DIV_BITS-1:0]               div_q;
  logic [BIT_W-1:0]                  bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]                  gap_cnt_q, gap_cnt_d;
  logic                              sync_n_q, sync_n_d;
  logic [CHANNELS-1:0]               din_q, din_d;
  logic [CHANNELS-1:0][DAC_BITS-1:0] codes_q, in_codes;
  logic [CHANNELS-1:0][WORD_BITS-1:0] word;
  logic                              tick, xfer, gap_done;

  function automatic logic [DAC_BITS-1:0] to_code(input logic signed [IN_BITS-1:0] x);
    logic signed [IN_BITS-1:0] v;
    // NOTE: blocking assignments are correct here: v is a combinational temporary, not state.
    v = x >>> SHIFT;
    if (v > CLAMP_MAX)      v = CLAMP_MAX;
    else if (v < CLAMP_MIN) v = CLAMP_MIN;
    return v[DAC_BITS-1:0] + DAC_OFFSET;
  endfunction

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      in_codes[k] = to_code(s_data[k*IN_BITS +: IN_BITS]);
      word[k]     = WORD_BITS'(codes_q[k]);
    end
  end

  assign tick     = cke && (div_q == '0);
  assign xfer     = s_valid && s_ready && cke;
  assign gap_done = (state_q == ST_GAP) && tick && (gap_cnt_q == GAP_W'(GAP_BITS-1));

  assign dac_sclk   = div_q[DIV_BITS-1];
  assign dac_sync_n = sync_n_q;
  assign dac_din    = din_q;

`ifdef OUTPUT_DAC_MCH_SKID_EN
  logic                              pend_valid_q;
  logic [CHANNELS-1:0][DAC_BITS-1:0] pend_q;
  logic [15:0]                       ovr_q;
  assign s_ready   = 1'b1;
  assign ovr_count = ovr_q;
`else
  assign s_ready   = (state_q == ST_IDLE);
  assign ovr_count = 16'h0000;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (xfer) state_d = ST_ARM;
      ST_ARM:   if (tick) state_d = ST_SHIFT;
      ST_SHIFT: if (tick && bit_cnt_q == '0) state_d = ST_GAP;
      ST_GAP: begin
        if (gap_done) begin
`ifdef OUTPUT_DAC_MCH_SKID_EN
          state_d = (xfer || pend_valid_q) ? ST_ARM : ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs only change on a tick, so a low cke freezes the frame in place.
  always_comb begin
    sync_n_d  = sync_n_q;
    din_d     = din_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    if (tick) begin
      case (state_q)
        ST_ARM: begin
          sync_n_d  = 1'b0;
          bit_cnt_d = BIT_W'(WORD_BITS-1);
          for (int k = 0; k < CHANNELS; k++) din_d[k] = word[k][WORD_BITS-1];
        end
        ST_SHIFT: begin
          if (bit_cnt_q == '0) begin
            sync_n_d  = 1'b1;
            din_d     = '0;
            gap_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q - BIT_W'(1);
            for (int k = 0; k < CHANNELS; k++) din_d[k] = word[k][bit_cnt_d];
          end
        end
        ST_GAP:  gap_cnt_d = gap_cnt_q + GAP_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q     <= '1;
      sync_n_q  <= 1'b1;
      din_q     <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      if (cke) div_q <= div_q - DIV_BITS'(1);
      sync_n_q  <= sync_n_d;
      din_q     <= din_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: code storage is a handful of flops, so it is reset rather than left as uninitialised memory.
      codes_q <= '0;
`ifdef OUTPUT_DAC_MCH_SKID_EN
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      ovr_q        <= '0;
`endif
    end else begin
`ifdef OUTPUT_DAC_MCH_SKID_EN
      if (xfer && (state_q == ST_IDLE || gap_done)) begin
        codes_q      <= in_codes;
        pend_valid_q <= 1'b0;
      end else if (gap_done && pend_valid_q) begin
        codes_q      <= pend_q;
        pend_valid_q <= 1'b0;
      end else if (xfer) begin
        pend_q       <= in_codes;
        pend_valid_q <= 1'b1;
        if (pend_valid_q && ovr_q != 16'hFFFF) ovr_q <= ovr_q + 16'd1;
      end
`else
      if (xfer) codes_q <= in_codes;
`endif
    end
  end

endmodule

// File: doc/output_dac_mch.md
OUTPUT_DAC_MCH -- requirements
Module: output_dac_mch

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of DAC channels, each shifted on its own data line; range 1..8.
REQ-002 SHALL have parameter IN_BITS, default 32: width of each signed input sample.
REQ-003 SHALL have parameter SHIFT, default 8: arithmetic right shift applied to each input sample.
REQ-004 SHALL have parameter DAC_BITS, default 12: DAC code width; range 8..16.
REQ-005 SHALL have parameter CTRL_BITS, default 4: zero control bits prefixed to each word; WORD_BITS = CTRL_BITS + DAC_BITS.
REQ-006 SHALL have parameter DIV_BITS, default 4: sclk period = 2^DIV_BITS clk cycles.
REQ-007 SHALL have parameter GAP_BITS, default 2: sync_n-high gap after each frame, in sclk periods; minimum 1.
REQ-008 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port clk, input, 1 bit: the only clock.
REQ-010 SHALL have port cke, input, 1 bit: clock enable; when low, all state holds.
REQ-011 SHALL have port s_data, input, CHANNELS*IN_BITS bits: signed samples; channel k occupies bits [k*IN_BITS +: IN_BITS].
REQ-012 SHALL have ports s_valid (input, 1 bit) and s_ready (output, 1 bit): sample handshake.
REQ-013 SHALL have port dac_sclk, output, 1 bit: serial clock, equal to divider MSB, free-running.
REQ-014 SHALL have port dac_sync_n, output, 1 bit: frame sync, low during the shift phase.
REQ-015 SHALL have port dac_din, output, CHANNELS bits: serial data per channel, MSB first.
REQ-016 SHALL have port ovr_count, output, 16 bits: count of overwritten samples; saturates at 0xFFFF.

Function
REQ-017 Divider SHALL be a DIV_BITS down-counter decrementing on each cke cycle; a "tick" is a cycle with cke=1 and divider=0.
REQ-018 Transfer SHALL occur on a cycle with s_valid=1, s_ready=1 and cke=1.
REQ-019 On transfer, each channel SHALL compute v = s_data_k >>> SHIFT, clamp to [-(2^(DAC_BITS-1)-1), +(2^(DAC_BITS-1)-1)], add 2^(DAC_BITS-1), and register the resulting code.
REQ-020 The FSM SHALL have states IDLE, ARM, SHIFT and GAP; transfer moves IDLE to ARM.
REQ-021 In ARM, the next tick SHALL move the FSM to SHIFT, drive dac_sync_n low and present word bit WORD_BITS-1 on dac_din.
REQ-022 In SHIFT, each tick SHALL present the next lower bit; after the tick presenting bit 0, the next tick SHALL raise dac_sync_n and enter GAP.
REQ-023 In GAP, the FSM SHALL count GAP_BITS ticks, then enter IDLE, with dac_din=0.
REQ-024 dac_sync_n SHALL be low for exactly WORD_BITS*2^DIV_BITS cke cycles per frame.
REQ-025 dac_sync_n, dac_din and dac_sclk SHALL all be registered outputs.
REQ-026 If cke=0 mid-frame, the frame SHALL stall with all outputs held, then resume.

Reset
REQ-027 When reset_n=0, the block SHALL immediately force: divider all-ones (dac_sclk=1), dac_sync_n=1, dac_din=0, FSM=IDLE, codes=0, pending buffer empty, ovr_count=0.
REQ-028 A reset mid-frame SHALL abort the frame; after release, the block SHALL start no frame until a new transfer.
REQ-029 After release, s_ready SHALL be 1 in the first cycle.

Configuration
REQ-030 The macro OUTPUT_DAC_MCH_SKID_EN SHALL control the pending-sample buffer.
REQ-031 Without OUTPUT_DAC_MCH_SKID_EN: s_ready = (state==IDLE); ovr_count SHALL be constant 0.
REQ-032 With OUTPUT_DAC_MCH_SKID_EN, s_ready SHALL be 1 at all times after reset.
REQ-033 With the macro, a transfer in a state other than IDLE SHALL store the processed codes in a one-entry pending buffer, replacing any existing entry.
REQ-034 With the macro, a replacement of a pending entry SHALL increment ovr_count.
REQ-035 With the macro, on leaving GAP with a pending entry, the FSM SHALL load the entry and go directly to ARM, emptying the buffer.
REQ-036 With the macro, a transfer in the same cycle as GAP exit SHALL be loaded directly, and ovr_count SHALL NOT increment.

Verification (CHANNELS=2, IN_BITS=32, SHIFT=8, DAC_BITS=12, CTRL_BITS=4, DIV_BITS=4)
REQ-037 Scenario: ch0=0x00010000, ch1=0xFFFF0000 -> dac_din[0] word 0x0900, dac_din[1] word 0x0700, MSB first.
REQ-038 Scenario: ch0=0x7FFFFFFF, ch1=0x80000000 -> words 0x0FFF and 0x0001 (clamp).
REQ-039 Scenario: single sample -> dac_sync_n low 256 clk; s_ready back to 1 after 2 gap ticks; 16 falling sclk edges with sync_n low.
REQ-040 Scenario: cke toggled 1/0 each cycle during a frame -> sync_n low 512 clk; data identical to REQ-037.
REQ-041 Scenario: reset_n pulsed low at bit 7 of a frame -> immediately sync_n=1, din=0, sclk=1; no frame after release.
REQ-042 Scenario, with OUTPUT_DAC_MCH_SKID_EN: 3 samples sent back-to-back during a frame -> the next frame carries the 3rd sample and ovr_count=1.
